mem_port_arbiter: RTL and testbench

//  Shares one unified single-port memory between the fetch stage (IF) and the memory-access stage (DM).
//  - Grants one transaction at a time; only one may be outstanding.
//  - DM has priority; an anti-starvation counter guarantees IF progress.
//  - Produces stall_f / stall_m so the pipeline holds while its access is pending.
//  - A watchdog terminates accesses the memory never answers.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state and access owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_DM = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // Which requester owns the access currently in flight; only meaningful in WAIT_x.
  function automatic owner_t ownerOf(input arb_state_t s);
    return (s == WAIT_DM) ? OWN_DM : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF) and
// data memory access (DM). One access outstanding at a time, DM preferred,
// IF protected from starvation, and a watchdog that aborts unanswered accesses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m,
  output logic              err
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);

  arb_state_t      state;
  logic [SC_W-1:0] starveCnt;
  logic [WD_W-1:0] wdCnt;
  owner_t          waitOwner;
  logic            dmWins;

  // DM takes the port unless IF is waiting and has already lost STARVE_MAX grants in a row.
  assign dmWins    = dm_req & (~if_req | (starveCnt < STARVE_LIM));
  assign waitOwner = ownerOf(state);

  // Pipeline holds while its own request is open and not yet answered.
  assign stall_f = if_req & ~if_rvalid;
  assign stall_m = dm_req & ~dm_rvalid;

  // Arbitration FSM with all memory-side and requester-side outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      starveCnt <= '0;
      wdCnt     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rvalid <= 1'b0;
      dm_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one cycle below.
      mem_req   <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (dmWins) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            state     <= WAIT_DM;
            // Count only grants that actually made IF wait; saturate so the limit stays sticky.
            if (if_req) begin
              starveCnt <= (starveCnt == STARVE_LIM) ? STARVE_LIM : starveCnt + SC_W'(1);
            end else begin
              starveCnt <= '0;
            end
          end else if (if_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            state     <= WAIT_IF;
            starveCnt <= '0;
          end
        end
        WAIT_IF, WAIT_DM: begin
          // A completion arriving in the final watchdog cycle still wins over the abort.
          if (mem_rvalid) begin
            if (waitOwner == OWN_DM) begin
              dm_rdata  <= mem_rdata;
              dm_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end
            wdCnt <= '0;
            state <= DONE;
          end else if (wdCnt == WD_LAST) begin
            if (waitOwner == OWN_DM) begin
              dm_rdata  <= '0;
              dm_rvalid <= 1'b1;
            end else begin
              if_rdata  <= '0;
              if_rvalid <= 1'b1;
            end
            err   <= 1'b1;
            wdCnt <= '0;
            state <= DONE;
          end else begin
            wdCnt <= wdCnt + WD_W'(1);
          end
        end
        DONE: begin
          // The owner's request is still high this cycle for the access just finished.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single-requester transactions
// plus hand-written sequences for contention, starvation, watchdog and reset.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall_f;
  logic        stall_m;
  logic        err;

  logic        respValid;
  logic        spurValid;
  int          memLat;
  logic        memSilent;
  int          checks;
  int          errors;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rvalid = respValid | spurValid;

  // Memory contents as seen by the bench.
  function automatic logic [31:0] memFunc(input logic [31:0] a);
    if (a == 32'h10) return 32'h00500093;
    return ~a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory model: answers memLat cycles after seeing mem_req, unless silent.
  initial begin
    logic [31:0] a;
    respValid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !memSilent) begin
        a = mem_addr;
        repeat (memLat) @(negedge clk);
        respValid = 1'b1;
        mem_rdata = memFunc(a);
        @(negedge clk);
        respValid = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  typedef struct {
    logic        isDm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          expGap;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  // One complete transaction from a single requester, checked end to end.
  task automatic doTxn(input int idx, input logic isDm, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int lat, input int expGap,
                       input logic [31:0] expRdata, input logic expErr, input logic silent);
    logic found, done, stallOk, otherSeen, reqAgain;
    int gap;
    memLat = lat;
    memSilent = silent;
    @(negedge clk);
    if (isDm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (mem_req) found = 1'b1;
    end
    check($sformatf("txn%0d_grant", idx), 32'(found), 32'd1);
    if (found) begin
      check($sformatf("txn%0d_mem_we", idx), 32'(mem_we), isDm ? 32'(we) : 32'd0);
      check($sformatf("txn%0d_mem_addr", idx), mem_addr, addr);
      check($sformatf("txn%0d_mem_wdata", idx), mem_wdata, isDm ? wdata : 32'd0);
      stallOk   = isDm ? stall_m : stall_f;
      otherSeen = 1'b0;
      reqAgain  = 1'b0;
      done      = 1'b0;
      gap       = 0;
      while (!done && gap < 200) begin
        @(negedge clk);
        gap++;
        if (mem_req) reqAgain = 1'b1;
        if (isDm ? if_rvalid : dm_rvalid) otherSeen = 1'b1;
        if (isDm ? dm_rvalid : if_rvalid) done = 1'b1;
        else if ((isDm ? stall_m : stall_f) !== 1'b1) stallOk = 1'b0;
      end
      check($sformatf("txn%0d_rvalid_gap", idx), gap, expGap);
      check($sformatf("txn%0d_rdata", idx), isDm ? dm_rdata : if_rdata, expRdata);
      check($sformatf("txn%0d_err", idx), 32'(err), 32'(expErr));
      check($sformatf("txn%0d_stall_release", idx), 32'(isDm ? stall_m : stall_f), 32'd0);
      check($sformatf("txn%0d_stall_held", idx), 32'(stallOk), 32'd1);
      check($sformatf("txn%0d_other_rvalid", idx), 32'(otherSeen), 32'd0);
      check($sformatf("txn%0d_single_issue", idx), 32'(reqAgain), 32'd0);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
    check($sformatf("txn%0d_rvalid_pulse", idx), 32'(isDm ? dm_rvalid : if_rvalid), 32'd0);
    check($sformatf("txn%0d_err_pulse", idx), 32'(err), 32'd0);
    $display("txn %0d: %s we=%0d addr=%08h lat=%0d rdata=%08h", idx, isDm ? "DM" : "IF",
             we, addr, lat, isDm ? dm_rdata : if_rdata);
    memSilent = 1'b0;
  endtask

  // Waits up to a bound for mem_req; returns 1 if seen.
  task automatic waitGrant(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
  endtask

  initial begin
    vec_t vecs[6];
    logic seen, anyBad;
    logic expOwner[6];

    checks = 0; errors = 0;
    rst = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    spurValid = 1'b0; memLat = 1; memSilent = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        1,  2,  32'h00500093, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 1,  2,  32'hFFFFFFBF, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h44, 32'h12345678, 3,  4,  32'hFFFFFFBB, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h20, 32'h0,        2,  3,  32'hFFFFFFDF, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h88, 32'h0,        63, 64, 32'hFFFFFF77, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h10, 32'h0,        5,  6,  32'h00500093, 1'b0};

    // Power-on reset state.
    repeat (3) @(negedge clk);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_rvalids", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      doTxn(v, vecs[v].isDm, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].lat,
            vecs[v].expGap, vecs[v].expRdata, vecs[v].expErr, 1'b0);
    end
    check("dm_rdata_hold", dm_rdata, 32'hFFFFFF77);

    // Spurious mem_rvalid while idle is ignored.
    @(negedge clk);
    spurValid = 1'b1;
    @(negedge clk);
    spurValid = 1'b0;
    anyBad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (if_rvalid || dm_rvalid || err || mem_req) anyBad = 1'b1;
    end
    check("spurious_idle", 32'(anyBad), 32'd0);
    check("spurious_if_rdata", if_rdata, 32'h00500093);

    // Both request together: DM first, IF once DM releases.
    memLat = 1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h30;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h50;
    waitGrant(seen);
    check("both_first_grant_addr", seen ? mem_addr : 32'hDEAD, 32'h50);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (dm_rvalid) seen = 1'b1;
    end
    check("both_dm_done", 32'(seen), 32'd1);
    dm_req = 1'b0;
    waitGrant(seen);
    check("both_second_grant_addr", seen ? mem_addr : 32'hDEAD, 32'h30);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (if_rvalid) seen = 1'b1;
    end
    check("both_if_rdata", if_rdata, 32'hFFFFFFCF);
    if_req = 1'b0;
    $display("txn both: DM 00000050 then IF 00000030");
    repeat (3) @(negedge clk);

    // Sustained contention: IF forced in after four DM grants.
    expOwner = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    for (int g = 0; g < 6; g++) begin
      waitGrant(seen);
      check($sformatf("starve_grant%0d_owner", g), seen ? 32'(mem_addr == 32'h200) : 32'hDEAD,
            32'(expOwner[g]));
      if (g == 3) check("starve_cnt_sat", 32'(dut.starveCnt), 32'd4);
      if (g == 4) check("starve_cnt_clear", 32'(dut.starveCnt), 32'd0);
      $display("txn starve %0d: owner=%s", g, (mem_addr == 32'h200) ? "DM" : "IF");
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (6) @(negedge clk);

    // Silent memory: watchdog abort, then a normal access.
    doTxn(10, 1'b1, 1'b0, 32'h80, 32'h0, 1, 64, 32'h0, 1'b1, 1'b1);
    doTxn(11, 1'b0, 1'b0, 32'h10, 32'h0, 2, 3, 32'h00500093, 1'b0, 1'b0);

    // Reset in the middle of a DM access, followed by the late memory answer.
    memLat = 6;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h60; dm_wdata = 32'h55AA55AA;
    waitGrant(seen);
    check("rstmid_grant", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0; dm_req = 1'b0;
    #1;
    check("rstmid_state", 32'(dut.state), 32'(IDLE));
    check("rstmid_mem_we", 32'(mem_we), 32'd0);
    check("rstmid_mem_wdata", mem_wdata, 32'd0);
    check("rstmid_rdata", if_rdata | dm_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    anyBad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (dm_rvalid || if_rvalid || err || mem_req) anyBad = 1'b1;
    end
    check("rstmid_silent", 32'(anyBad), 32'd0);
    $display("txn rstmid: DM write 00000060 abandoned by reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
